// File: rtl/dw_fp_mac_acc.sv
// Sequential FP dot-product engine: one fused multiply-add per accepted operand pair.
// Optional macro DW_FP_MAC_ACC_BIAS_EN adds inst_bias as the initial accumulator value.

module dw_fp_mac_acc_mac #(
  parameter int SIG_W = 23,
  parameter int EXP_W = 8,
  parameter int IEEE  = 0
) (
  input  logic [SIG_W+EXP_W:0] a,
  input  logic [SIG_W+EXP_W:0] b,
  input  logic [SIG_W+EXP_W:0] c,
  input  logic [2:0]           rnd,
  output logic [SIG_W+EXP_W:0] z,
  output logic [7:0]           status
);
  localparam int W  = SIG_W + EXP_W + 1;
  localparam int MW = SIG_W + 1;
  localparam int PW = 2*SIG_W + 2;
  localparam int WF = PW + 3;
  localparam int WN = WF + 1;
  localparam int EW = EXP_W + 10;
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] NORM_OFS = EW'(2*SIG_W + 4);
  localparam logic signed [EW-1:0] E_ONE    = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
  localparam bit KEEP_PAYLOAD   = (IEEE != 0);

  logic sa, sb, sc, sp;
  logic [EXP_W-1:0] ea, eb, ec;
  logic [SIG_W-1:0] fa, fb, fc;
  logic a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, a_nan, b_nan, c_nan;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign {sc, ec, fc} = c;
  assign sp     = sa ^ sb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign c_zero = (ec == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign c_inf  = (ec == '1) && (fc == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign c_nan  = (ec == '1) && (fc != '0);

  logic [PW-1:0] mp, p_frame, c_frame, big_m, small_m;
  logic signed [EW-1:0] ep, ecs, e_big, d, er;
  logic [EW-1:0] lead;
  logic [WF-1:0] small_ext, small_sh, big_al;
  logic [WN-1:0] sum, norm;
  logic [MW-1:0] mant;
  logic [MW:0]   mant_r;
  logic [SIG_W-1:0] frac;
  logic sticky_al, p_big, s_big, eff_sub, g, st, inc, to_inf;
  logic [W-1:0] gen_z, nan_src;
  logic [7:0]   gen_st;

  // Both operands are aligned with their leading one at bit PW-1, so the
  // larger exponent (or larger mantissa on a tie) never yields a negative sum.
  always_comb begin
    mp      = PW'({1'b1, fa}) * PW'({1'b1, fb});
    p_frame = mp[PW-1] ? mp : (mp << 1);
    ep      = $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS + $signed(EW'(mp[PW-1]));
    c_frame = c_zero ? '0 : {1'b1, fc, {MW{1'b0}}};
    ecs     = $signed(EW'(ec));
    p_big   = c_zero || (ep > ecs) || ((ep == ecs) && (p_frame >= c_frame));
    big_m   = p_big ? p_frame : c_frame;
    small_m = p_big ? c_frame : p_frame;
    e_big   = p_big ? ep : ecs;
    s_big   = p_big ? sp : sc;
    d       = p_big ? (ep - ecs) : (ecs - ep);
    if (d > EW'(WN)) d = EW'(WN);
    small_ext = {small_m, 3'b000};
    small_sh  = small_ext >> d;
    sticky_al = ((small_sh << d) != small_ext);
    big_al    = {big_m, 3'b000};
    eff_sub   = !c_zero && (sp != sc);
    sum = eff_sub ? ({1'b0, big_al} - {1'b0, small_sh | WF'(sticky_al)})
                  : ({1'b0, big_al} + {1'b0, small_sh | WF'(sticky_al)});

    lead = '0;
    for (int i = 0; i < WN; i++) begin
      if (sum[i]) lead = EW'(i);
    end
    norm = sum << (EW'(WN-1) - lead);
    er   = e_big + $signed(lead) - NORM_OFS;
    mant = norm[WN-1 -: MW];
    g    = norm[WN-1-MW];
    st   = |norm[WN-2-MW:0];

    case (rnd)
      3'd1:    inc = 1'b0;
      3'd2:    inc = (g | st) & ~s_big;
      3'd3:    inc = (g | st) & s_big;
      3'd4:    inc = g;
      3'd5:    inc = g | st;
      default: inc = g & (st | mant[0]);
    endcase
    mant_r = {1'b0, mant} + (MW+1)'(inc);
    if (mant_r[MW]) begin
      frac = mant_r[SIG_W:1];
      er   = er + E_ONE;
    end else begin
      frac = mant_r[SIG_W-1:0];
    end

    to_inf = (rnd == 3'd2) ? !s_big :
             (rnd == 3'd3) ? s_big  :
             (rnd != 3'd1);
    gen_st    = '0;
    gen_st[5] = g | st;
    if (sum == '0) begin
      gen_z  = {(rnd == 3'd3), {(W-1){1'b0}}};
      gen_st = 8'h01;
    end else if (er >= EMAX) begin
      gen_z     = to_inf ? {s_big, {EXP_W{1'b1}}, {SIG_W{1'b0}}}
                         : {s_big, {(EXP_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}};
      gen_st    = 8'h30;
      gen_st[1] = to_inf;
    end else if (er < E_ONE) begin
      gen_z  = {s_big, {(W-1){1'b0}}};
      gen_st = 8'h29;
    end else begin
      gen_z = {s_big, er[EXP_W-1:0], frac};
    end

    nan_src = a_nan ? a : (b_nan ? b : c);
    z       = gen_z;
    status  = gen_st;
    if (a_nan || b_nan || c_nan) begin
      z      = KEEP_PAYLOAD ? nan_src : QNAN;
      status = '0;
    end else if ((a_inf && b_zero) || (a_zero && b_inf) ||
                 ((a_inf || b_inf) && c_inf && (sp != sc))) begin
      z      = QNAN;
      status = 8'h04;
    end else if (a_inf || b_inf) begin
      z      = {sp, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      status = 8'h02;
    end else if (c_inf) begin
      z      = c;
      status = 8'h02;
    end else if (a_zero || b_zero) begin
      if (c_zero) begin
        z      = {(sp && sc) || ((sp != sc) && (rnd == 3'd3)), {(W-1){1'b0}}};
        status = 8'h01;
      end else begin
        z      = c;
        status = '0;
      end
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for inst_start; all outputs low
// ACC   | accepting operand pairs, one MAC per handshake
// DONE  | result presented, held until out_ready
module dw_fp_mac_acc #(
  parameter int inst_sig_width       = 23,
  parameter int inst_exp_width       = 8,
  parameter int inst_ieee_compliance = 0,
  parameter int LEN_WIDTH            = 8
) (
  input  logic                                     inst_clk,
  input  logic                                     inst_rst_n,
  input  logic                                     inst_start,
  input  logic [LEN_WIDTH-1:0]                     inst_len,
  input  logic [2:0]                               inst_rnd,
  input  logic                                     inst_in_valid,
  output logic                                     inst_in_ready,
  input  logic [inst_sig_width+inst_exp_width:0]   inst_a,
  input  logic [inst_sig_width+inst_exp_width:0]   inst_b,
`ifdef DW_FP_MAC_ACC_BIAS_EN
  input  logic [inst_sig_width+inst_exp_width:0]   inst_bias,
`endif
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [inst_sig_width+inst_exp_width:0]   z_inst,
  output logic [7:0]                               status_inst,
  output logic                                     inst_busy
);
  localparam int W = inst_sig_width + inst_exp_width + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q, count;
  logic [2:0]           rnd_q;
  logic [W-1:0]         acc, mac_z, init_val;
  logic [7:0]           mac_st, init_st;
  logic [5:0]           sticky;

`ifdef DW_FP_MAC_ACC_BIAS_EN
  logic bias_zero, bias_inf;
  assign bias_zero = (inst_bias[W-2:inst_sig_width] == '0);
  assign bias_inf  = (inst_bias[W-2:inst_sig_width] == '1) &&
                     (inst_bias[inst_sig_width-1:0] == '0);
  assign init_val  = inst_bias;
  assign init_st   = {6'b0, bias_inf, bias_zero};
`else
  assign init_val  = '0;
  assign init_st   = 8'h01;
`endif

  dw_fp_mac_acc_mac #(
    .SIG_W (inst_sig_width),
    .EXP_W (inst_exp_width),
    .IEEE  (inst_ieee_compliance)
  ) u_mac (
    .a      (inst_a),
    .b      (inst_b),
    .c      (acc),
    .rnd    (rnd_q),
    .z      (mac_z),
    .status (mac_st)
  );

  always_ff @(posedge inst_clk or negedge inst_rst_n) begin
    if (!inst_rst_n) begin
      state         <= S_IDLE;
      acc           <= '0;
      count         <= '0;
      sticky        <= '0;
      len_q         <= '0;
      rnd_q         <= '0;
      inst_in_ready <= 1'b0;
      out_valid     <= 1'b0;
      z_inst        <= '0;
      status_inst   <= '0;
      inst_busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inst_start) begin
            acc       <= init_val;
            count     <= '0;
            sticky    <= '0;
            len_q     <= inst_len;
            rnd_q     <= inst_rnd;
            inst_busy <= 1'b1;
            if (inst_len == '0) begin
              state       <= S_DONE;
              out_valid   <= 1'b1;
              z_inst      <= init_val;
              status_inst <= init_st;
            end else begin
              state         <= S_ACC;
              inst_in_ready <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (inst_in_valid) begin
            acc    <= mac_z;
            sticky <= sticky | mac_st[7:2];
            count  <= count + LEN_WIDTH'(1);
            if (count == len_q - LEN_WIDTH'(1)) begin
              state         <= S_DONE;
              inst_in_ready <= 1'b0;
              out_valid     <= 1'b1;
              z_inst        <= mac_z;
              status_inst   <= {sticky | mac_st[7:2], mac_st[1:0]};
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            z_inst      <= '0;
            status_inst <= '0;
            inst_busy   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
